// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data memory arbiter: data width, FSM state and owner encodings.
package data_mem_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating host wait counter; flags when the host has waited at least LIMIT cycles.
module arb_starve_counter #(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_at_limit
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count < LIM)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_at_limit = (r_count >= LIM);

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store path and the host/debug port.
// Optional host anti-starvation is enabled by defining ARB_FAIR_EN.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int AW            = 6,
  parameter int DW            = DATA_W,
  parameter int HOST_WAIT_MAX = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_ack,
  output logic          o_cpu_stall,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [DW-1:0] i_host_wdata,
  output logic [DW-1:0] o_host_rdata,
  output logic          o_host_ack,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [1:0]    o_state
);

  // Handshake: a requester raises req with its cmd fields and holds them until its
  // one-cycle ack; fields are captured only in the IDLE cycle that grants it.

  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_is_write;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_host_rdata;
  logic          r_cpu_ack;
  logic          r_host_ack;

  logic w_cpu_elig;
  logic w_host_elig;
  logic w_host_starved;
  logic w_grant_host;
  logic w_grant_cpu;
  logic w_host_granted_now;

  // A requester whose ack is showing this cycle is still holding the old request.
  assign w_cpu_elig         = i_cpu_req & ~r_cpu_ack;
  assign w_host_elig        = i_host_req & ~r_host_ack;
  assign w_grant_host       = w_host_elig & (w_host_starved | ~w_cpu_elig);
  assign w_grant_cpu        = w_cpu_elig & ~w_grant_host;
  assign w_host_granted_now = (r_state == ST_IDLE) & w_grant_host;

`ifdef ARB_FAIR_EN
  arb_starve_counter #(
    .LIMIT (HOST_WAIT_MAX)
  ) u_starve (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (i_host_req & ~w_host_granted_now),
    .i_clear    (~i_host_req | w_host_granted_now),
    .o_at_limit (w_host_starved)
  );
`else
  logic w_unused_cfg;
  assign w_host_starved = 1'b0;
  assign w_unused_cfg   = (HOST_WAIT_MAX > 0) & w_host_granted_now;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_CPU;
      r_is_write   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_host) begin
            r_owner     <= OWN_HOST;
            r_is_write  <= i_host_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_host_we;
            r_mem_addr  <= i_host_addr;
            r_mem_wdata <= i_host_wdata;
            r_state     <= ST_ACCESS;
          end else if (w_grant_cpu) begin
            r_owner     <= OWN_CPU;
            r_is_write  <= i_cpu_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_cpu_we;
            r_mem_addr  <= i_cpu_addr;
            r_mem_wdata <= i_cpu_wdata;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          // Synchronous-read data is on i_mem_rdata now; writes leave rdata untouched.
          if (r_owner == OWN_HOST) begin
            r_host_ack <= 1'b1;
            if (!r_is_write) r_host_rdata <= i_mem_rdata;
          end else begin
            r_cpu_ack <= 1'b1;
            if (!r_is_write) r_cpu_rdata <= i_mem_rdata;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_ack    = r_cpu_ack;
  assign o_cpu_stall  = i_cpu_req & ~r_cpu_ack;
  assign o_host_rdata = r_host_rdata;
  assign o_host_ack   = r_host_ack;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_state      = r_state;

endmodule
